in_shift_accumulator: RTL and testbench
=======================================

IN_SHIFT_ACCUMULATOR -- requirements
Module: in_shift_accumulator

Interface
REQ-001 Parameter WIDTH, default 32, ISR and FIFO data width; only 32 is supported.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 pin_data  in  32  pin sample, already base-shifted and count-masked by the pin block; the block uses the LSBs.
REQ-005 in_valid  in  1  IN instruction presented this cycle.
REQ-006 in_count  in  5  IN bit count; 1..31 literal, 0 means 32.
REQ-007 shift_right  in  1  1 = ISR shifts right (new bits enter at MSB); 0 = shifts left (new bits enter at LSB).
REQ-008 autopush_en  in  1  enable autopush.
REQ-009 push_threshold  in  5  autopush threshold; 1..31 literal, 0 means 32.
REQ-010 push_req  in  1  explicit PUSH instruction presented this cycle.
REQ-011 push_block  in  1  PUSH stalls while the buffer is unavailable.
REQ-012 isr_clear  in  1  clear ISR and count (restart / MOV).
REQ-013 in_ready  out  1  IN or PUSH completes this cycle; 0 = stall.
REQ-014 fifo_data  out  32  pushed word toward RX FIFO.
REQ-015 fifo_valid  out  1  fifo_data valid.
REQ-016 fifo_ready  in  1  RX FIFO accepts this cycle.
REQ-017 isr_value  out  32  current ISR contents, registered.
REQ-018 isr_count  out  6  current shift count, 0..32, registered.
REQ-019 rx_overflow  out  1  one-cycle pulse when a non-blocking PUSH meets an unavailable buffer.

Function
REQ-020 n = in_count, with 0 decoded as 32; th = push_threshold, with 0 decoded as 32.
REQ-021 Left IN: ISR <= (ISR << n) | (pin_data & ((1<<n)-1)); n=32 gives ISR <= pin_data.
REQ-022 Right IN: ISR <= (ISR >> n) | (pin_data << (32-n)); n=32 gives ISR <= pin_data.
REQ-023 On an accepted IN, isr_count <= min(isr_count + n, 32), saturating.
REQ-024 buf_free = !fifo_valid || fifo_ready, combinational.
REQ-025 Autopush triggers on an accepted IN when autopush_en is 1 and the saturated new count >= th.
REQ-026 in_ready = 0 only when:
- in_valid is 1, the autopush trigger is true and buf_free is 0; or
- push_req and push_block are 1 and buf_free is 0.
REQ-027 in_ready = 1 in all other cases.
REQ-028 A stalled IN or PUSH leaves ISR, isr_count and the buffer unchanged.
REQ-029 Autopush on an accepted IN:
- fifo_data <= shifted ISR value;
- fifo_valid <= 1;
- ISR <= 0 and isr_count <= 0 at the same edge.
REQ-030 Accepted PUSH with buf_free = 1: fifo_data <= ISR, fifo_valid <= 1, ISR <= 0, isr_count <= 0.
REQ-031 Non-blocking PUSH with buf_free = 0: fifo_data and fifo_valid are unchanged, ISR and count are cleared, and rx_overflow pulses on the next cycle.
REQ-032 Output buffer holds fifo_data stable while fifo_valid && !fifo_ready; on fifo_ready with no new push, fifo_valid <= 0.
REQ-033 Push and fifo_ready in the same cycle: buffer reloads with the new word and fifo_valid stays 1.
REQ-034 Latency: ISR and count update at the edge ending the accepted cycle; fifo_valid rises one cycle after a push-causing IN or PUSH.
REQ-035 push_req and in_valid together: PUSH executes and the IN is discarded with no shift.
REQ-036 isr_clear has priority over IN and PUSH: ISR and count are zeroed and the buffer is unaffected.
REQ-037 No autopush occurs when autopush_en is 0; the count saturates at 32 and shifting continues.

Reset
REQ-038 On reset_n low, without waiting for a clock edge: ISR, isr_count, fifo_data, fifo_valid and rx_overflow go to 0; in_ready then follows its combinational rule.
REQ-039 Reset mid-operation discards any pending buffered word; no fifo_valid pulse follows reset release.

Verification
REQ-040 Left shift, autopush on, th=0 (32); IN 8 bits of 0xA1, 0xB2, 0xC3, 0xD4 -> fifo_data 0x A1B2C3D4, fifo_valid 1, isr_count 0.
REQ-041 Right shift, autopush on, th=0; single IN in_count=0 with pin_data 0x12345678 -> fifo_data 0x12345678 next cycle.
REQ-042 fifo_ready=0 with buffer full; IN that triggers autopush -> in_ready 0 and ISR unchanged; raise fifo_ready -> in_ready 1 in the same cycle, buffer holds the new word.
REQ-043 Buffer full, fifo_ready=0; PUSH with push_block=0 -> fifo_data unchanged, ISR 0, rx_overflow single pulse.
REQ-044 Autopush off; five IN of 8 bits -> isr_count 32 (saturated), isr_value equals the last four bytes.
REQ-045 Assert reset_n low while fifo_valid=1 and isr_count=16 -> all outputs 0 immediately, no push after release.

Source files
------------

// File: rtl/in_shift_accumulator.sv
// Input shift register with autopush/PUSH into a one-word RX buffer; ISR/count update at the accepted edge, fifo_valid one cycle later.
// Backpressure: in_ready drops only when a push is needed while the buffer is held (fifo_valid && !fifo_ready); stalls change no state.
module in_shift_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_data,
  input  logic             in_valid,
  input  logic [4:0]       in_count,
  input  logic             shift_right,
  input  logic             autopush_en,
  input  logic [4:0]       push_threshold,
  input  logic             push_req,
  input  logic             push_block,
  input  logic             isr_clear,
  output logic             in_ready,
  output logic [WIDTH-1:0] fifo_data,
  output logic             fifo_valid,
  input  logic             fifo_ready,
  output logic [WIDTH-1:0] isr_value,
  output logic [5:0]       isr_count,
  output logic             rx_overflow
);

  logic [WIDTH-1:0] isr_q, isr_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] fdat_q, fdat_d;
  logic             fvld_q, fvld_d;
  logic             ovf_q, ovf_d;

  logic [5:0]       n_bits, th_bits, new_cnt;
  logic [6:0]       cnt_sum;
  logic [4:0]       rsh;
  logic [WIDTH-1:0] low_mask, shifted;
  logic             buf_free, trig;

  always_comb begin
    n_bits  = (in_count == 5'd0) ? 6'd32 : {1'b0, in_count};
    th_bits = (push_threshold == 5'd0) ? 6'd32 : {1'b0, push_threshold};
    cnt_sum = {1'b0, cnt_q} + {1'b0, n_bits};
    new_cnt = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];
    // For counts 1..31 the right-shift entry offset is 32-n, i.e. -n mod 32.
    rsh      = 5'd0 - in_count;
    low_mask = ~({WIDTH{1'b1}} << in_count);
    if (in_count == 5'd0)
      shifted = pin_data;
    else if (shift_right)
      shifted = (isr_q >> in_count) | (pin_data << rsh);
    else
      shifted = (isr_q << in_count) | (pin_data & low_mask);
    buf_free = !fvld_q || fifo_ready;
    trig     = autopush_en && (new_cnt >= th_bits);
    in_ready = !(!buf_free && ((in_valid && trig) || (push_req && push_block)));
  end

  always_comb begin
    isr_d  = isr_q;
    cnt_d  = cnt_q;
    fdat_d = fdat_q;
    fvld_d = fvld_q && !fifo_ready;
    ovf_d  = 1'b0;
    if (isr_clear) begin
      isr_d = '0;
      cnt_d = '0;
    end else if (in_ready) begin
      if (push_req) begin
        // Only a non-blocking PUSH reaches here with the buffer held.
        if (buf_free) begin
          fdat_d = isr_q;
          fvld_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        isr_d = '0;
        cnt_d = '0;
      end else if (in_valid) begin
        if (trig) begin
          fdat_d = shifted;
          fvld_d = 1'b1;
          isr_d  = '0;
          cnt_d  = '0;
        end else begin
          isr_d = shifted;
          cnt_d = new_cnt;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      isr_q  <= '0;
      cnt_q  <= '0;
      fdat_q <= '0;
      fvld_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      isr_q  <= isr_d;
      cnt_q  <= cnt_d;
      fdat_q <= fdat_d;
      fvld_q <= fvld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fifo_data   = fdat_q;
  assign fifo_valid  = fvld_q;
  assign isr_value   = isr_q;
  assign isr_count   = cnt_q;
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_in_shift_accumulator.sv
// Bench for in_shift_accumulator: directed scenarios then randomized traffic against a bit-window reference model.
module tb_in_shift_accumulator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] pin_data;
  logic        in_valid, shift_right, autopush_en, push_req, push_block, isr_clear, fifo_ready;
  logic [4:0]  in_count, push_threshold;
  logic        in_ready, fifo_valid, rx_overflow;
  logic [31:0] fifo_data, isr_value;
  logic [5:0]  isr_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_isr, m_fd;
  int          m_cnt;
  bit          m_fv, m_ovf;

  in_shift_accumulator #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .pin_data(pin_data), .in_valid(in_valid),
    .in_count(in_count), .shift_right(shift_right), .autopush_en(autopush_en),
    .push_threshold(push_threshold), .push_req(push_req), .push_block(push_block),
    .isr_clear(isr_clear), .in_ready(in_ready), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .fifo_ready(fifo_ready), .isr_value(isr_value),
    .isr_count(isr_count), .rx_overflow(rx_overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // The ISR is a 32-bit window over the incoming bit stream.
  function automatic logic [31:0] m_shift(logic [31:0] isr, logic [31:0] pin, int n, bit right);
    logic [63:0] w;
    if (right) begin
      w = {pin, isr} >> n;
      return w[31:0];
    end
    w = {isr, pin << (32 - n)} << n;
    return w[63:32];
  endfunction

  task automatic m_reset();
    m_isr = 0; m_cnt = 0; m_fd = 0; m_fv = 0; m_ovf = 0;
  endtask

  task automatic chk_outputs(input string pfx);
    chk({pfx, "_isr_value"}, isr_value, m_isr);
    chk({pfx, "_isr_count"}, {26'd0, isr_count}, 32'(m_cnt));
    chk({pfx, "_fifo_valid"}, {31'd0, fifo_valid}, {31'd0, m_fv});
    chk({pfx, "_fifo_data"}, fifo_data, m_fd);
    chk({pfx, "_rx_overflow"}, {31'd0, rx_overflow}, {31'd0, m_ovf});
  endtask

  // Entered and left at posedge+1: drive, check in_ready mid-cycle, clock, check state.
  task automatic cyc(input logic iv, input logic [4:0] ic, input logic [31:0] pd,
                     input logic sr, input logic ae, input logic [4:0] th,
                     input logic pr, input logic pb, input logic clr, input logic fr);
    int  n, t, nc;
    bit  trig, bfree, rdy;
    in_valid = iv; in_count = ic; pin_data = pd; shift_right = sr; autopush_en = ae;
    push_threshold = th; push_req = pr; push_block = pb; isr_clear = clr; fifo_ready = fr;
    n  = (ic == 0) ? 32 : int'(ic);
    t  = (th == 0) ? 32 : int'(th);
    nc = (m_cnt + n > 32) ? 32 : m_cnt + n;
    trig  = ae && (nc >= t);
    bfree = !m_fv || fr;
    rdy   = !((iv && trig && !bfree) || (pr && pb && !bfree));
    #3;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    @(posedge clock);
    m_ovf = 0;
    if (fr) m_fv = 0;
    if (clr) begin
      m_isr = 0; m_cnt = 0;
    end else if (rdy && pr) begin
      if (bfree) begin m_fd = m_isr; m_fv = 1; end
      else m_ovf = 1;
      m_isr = 0; m_cnt = 0;
    end else if (rdy && iv) begin
      if (trig) begin
        m_fd = m_shift(m_isr, pd, n, sr); m_fv = 1; m_isr = 0; m_cnt = 0;
      end else begin
        m_isr = m_shift(m_isr, pd, n, sr); m_cnt = nc;
      end
    end
    #1;
    chk_outputs("cyc");
  endtask

  task automatic idle(input logic fr);
    cyc(0, 5'd0, 32'h0, 0, 0, 5'd0, 0, 0, 0, fr);
  endtask

  initial begin
    logic [31:0] pins [4];
    pins[0] = 32'hA1; pins[1] = 32'hB2; pins[2] = 32'hC3; pins[3] = 32'hD4;
    reset_n = 1'b0;
    {in_valid, shift_right, autopush_en, push_req, push_block, isr_clear, fifo_ready} = '0;
    in_count = 0; push_threshold = 0; pin_data = 0;
    m_reset();
    #12;
    chk_outputs("reset");
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1 reset_n = 1'b1;

    // Left shift, autopush at 32: four bytes assemble into one word.
    for (int i = 0; i < 4; i++) cyc(1, 5'd8, pins[i], 0, 1, 5'd0, 0, 0, 0, 0);
    chk("req40_data", fifo_data, 32'hA1B2C3D4);
    chk("req40_valid", {31'd0, fifo_valid}, 32'd1);
    chk("req40_count", {26'd0, isr_count}, 32'd0);

    // Buffer held: autopush-triggering IN stalls, then completes when fifo_ready rises.
    cyc(1, 5'd8, 32'h5A, 0, 1, 5'd8, 0, 0, 0, 0);
    chk("req42_isr_held", isr_value, 32'h0);
    chk("req42_data_held", fifo_data, 32'hA1B2C3D4);
    cyc(1, 5'd8, 32'h5A, 0, 1, 5'd8, 0, 0, 0, 1);
    chk("req42_new_word", fifo_data, 32'h5A);

    // Non-blocking PUSH into a held buffer overflows.
    cyc(1, 5'd8, 32'h77, 0, 0, 5'd0, 0, 0, 0, 0);
    cyc(0, 5'd0, 32'h0, 0, 0, 5'd0, 1, 0, 0, 0);
    chk("req43_data", fifo_data, 32'h5A);
    chk("req43_ovf", {31'd0, rx_overflow}, 32'd1);
    chk("req43_isr", isr_value, 32'h0);
    idle(0);
    chk("req43_ovf_pulse", {31'd0, rx_overflow}, 32'd0);

    // Right shift, full-width IN.
    idle(1);
    cyc(1, 5'd0, 32'h12345678, 1, 1, 5'd0, 0, 0, 0, 0);
    chk("req41_data", fifo_data, 32'h12345678);

    // Autopush off: count saturates, ISR keeps the last four bytes.
    idle(1);
    for (int i = 1; i <= 5; i++) cyc(1, 5'd8, 32'(i * 32'h11), 0, 0, 5'd0, 0, 0, 0, 0);
    chk("req44_count", {26'd0, isr_count}, 32'd32);
    chk("req44_isr", isr_value, 32'h22334455);

    // Reset mid-operation with a held word and a half-full ISR.
    cyc(0, 5'd0, 32'h0, 0, 0, 5'd0, 1, 1, 0, 0);
    cyc(1, 5'd8, 32'hEE, 0, 0, 5'd0, 0, 0, 0, 0);
    cyc(1, 5'd8, 32'hFF, 0, 0, 5'd0, 0, 0, 0, 0);
    chk("req45_pre_count", {26'd0, isr_count}, 32'd16);
    chk("req45_pre_valid", {31'd0, fifo_valid}, 32'd1);
    {in_valid, push_req, isr_clear, fifo_ready} = '0;
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk_outputs("req45_async");
    @(posedge clock); #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle(0);
    chk("req45_no_push", {31'd0, fifo_valid}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 99) < 60, 5'($urandom), $urandom, 1'($urandom), $urandom_range(0, 99) < 70,
          5'($urandom), $urandom_range(0, 99) < 10, 1'($urandom), $urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 50);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
